alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl.sv | 131 +++++++++++++
 tb/tb_alarm_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Alarm controller: stored alarm time, ring/snooze state machine and buzzer tone divider.
// Driven entirely from the timekeeping stage's hour/minute/second values.
module alarm_ctrl #(
  parameter int unsigned TONE_DIV   = 50000,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic       alarm_en,
  input  logic       set_alarm,
  input  logic [5:0] set_hour,
  input  logic [5:0] set_minute,
  input  logic       stop,
  input  logic       snooze,
  output logic [5:0] alm_hour,
  output logic [5:0] alm_minute,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer,
  output logic       set_err
);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

  localparam int unsigned         DIV_W     = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(TONE_DIV - 1);
  localparam logic [6:0]          RING_LAST = 7'(RING_SEC - 1);

  state_t           state, state_nx;
  logic [5:0]       second_q;
  logic [5:0]       snz_hour, snz_minute;
  logic [6:0]       ring_cnt;
  logic [DIV_W-1:0] div_cnt;

  logic       strobe, set_ok, alarm_hit, snooze_hit, ring_done, stay_ringing;
  logic [6:0] min_sum;
  logic [5:0] tgt_hour, tgt_minute;

  assign strobe     = (second != second_q);
  assign set_ok     = set_alarm && (set_hour <= 6'd23) && (set_minute <= 6'd59);
  assign alarm_hit  = strobe && (second == 6'd0) && (hour == alm_hour) && (minute == alm_minute);
  assign snooze_hit = strobe && (second == 6'd0) && (hour == snz_hour) && (minute == snz_minute);
  assign ring_done  = strobe && (ring_cnt == RING_LAST);
  assign stay_ringing = (state == RINGING) && (state_nx == RINGING);

  // Snooze target: minute wraps mod 60 with carry into hour, hour wraps mod 24.
  assign min_sum = {1'b0, minute} + 7'(SNOOZE_MIN);
  always_comb begin
    tgt_hour   = hour;
    tgt_minute = min_sum[5:0];
    if (min_sum >= 7'd60) begin
      tgt_minute = 6'(min_sum - 7'd60);
      tgt_hour   = (hour >= 6'd23) ? 6'd0 : hour + 6'd1;
    end
  end

  // Priority: alarm_en=0 > accepted set_alarm > stop > snooze > match/timeout.
  always_comb begin
    state_nx = state;
    if (!alarm_en) begin
      state_nx = IDLE;
    end else if (set_ok && (state == RINGING || state == SNOOZE)) begin
      state_nx = ARMED;
    end else begin
      unique case (state)
        IDLE:    state_nx = ARMED;
        ARMED:   if (alarm_hit) state_nx = RINGING;
        RINGING: begin
          if (stop)           state_nx = ARMED;
          else if (snooze)    state_nx = SNOOZE;
          else if (ring_done) state_nx = ARMED;
        end
        SNOOZE: begin
          if (stop)            state_nx = ARMED;
          else if (snooze_hit) state_nx = RINGING;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
      second_q   <= '0;
      alm_hour   <= '0;
      alm_minute <= '0;
      snz_hour   <= '0;
      snz_minute <= '0;
      set_err    <= 1'b0;
      ring_cnt   <= '0;
      div_cnt    <= '0;
      buzzer     <= 1'b0;
    end else begin
      state    <= state_nx;
      ringing  <= (state_nx == RINGING);
      snoozing <= (state_nx == SNOOZE);
      second_q <= second;
      set_err  <= set_alarm && !set_ok;
      if (set_ok) begin
        alm_hour   <= set_hour;
        alm_minute <= set_minute;
      end
      if (state == RINGING && state_nx == SNOOZE) begin
        snz_hour   <= tgt_hour;
        snz_minute <= tgt_minute;
      end
      // Counter and divider restart on every RINGING entry, idle at zero elsewhere.
      if (stay_ringing) begin
        if (strobe) ring_cnt <= ring_cnt + 7'd1;
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          buzzer  <= ~buzzer;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else begin
        ring_cnt <= '0;
        div_cnt  <= '0;
        buzzer   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: vector table through a scoreboard queue,
// then hand-written buzzer-period and asynchronous-reset sequences.
module tb_alarm_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned RS = 3;
  localparam int unsigned SM = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] hour, minute, second;
  logic       alarm_en, set_alarm, stop, snooze;
  logic [5:0] set_hour, set_minute;
  logic [5:0] alm_hour, alm_minute;
  logic       ringing, snoozing, buzzer, set_err;

  int compared   = 0;
  int mismatched = 0;

  alarm_ctrl #(.TONE_DIV(TD), .RING_SEC(RS), .SNOOZE_MIN(SM)) dut (
    .clk(clk), .rst(rst), .hour(hour), .minute(minute), .second(second),
    .alarm_en(alarm_en), .set_alarm(set_alarm), .set_hour(set_hour),
    .set_minute(set_minute), .stop(stop), .snooze(snooze),
    .alm_hour(alm_hour), .alm_minute(alm_minute), .ringing(ringing),
    .snoozing(snoozing), .buzzer(buzzer), .set_err(set_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, set;
    logic [5:0] sh, sm;
    logic       stp, snz;
    logic [5:0] h, m, s;
    logic       e_ring, e_snz, e_err;
    logic [5:0] e_ah, e_am;
  } vec_t;

  typedef struct {
    logic       ring, snz, err;
    logic [5:0] ah, am;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(int en, int set, int sh, int sm, int stp, int snz,
                              int h, int m, int s, int er, int es, int ee, int eah, int eam);
    vec_t v;
    v.en = 1'(en);  v.set = 1'(set); v.sh = 6'(sh); v.sm = 6'(sm);
    v.stp = 1'(stp); v.snz = 1'(snz);
    v.h = 6'(h); v.m = 6'(m); v.s = 6'(s);
    v.e_ring = 1'(er); v.e_snz = 1'(es); v.e_err = 1'(ee);
    v.e_ah = 6'(eah); v.e_am = 6'(eam);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour = 6'(h); minute = 6'(m); second = 6'(s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    rst = 1'b1; alarm_en = 1'b0; set_alarm = 1'b0; stop = 1'b0; snooze = 1'b0;
    set_hour = '0; set_minute = '0; set_time(0, 0, 0);
    #1;
    chk("rst_ringing",  int'(ringing), 0);
    chk("rst_snoozing", int'(snoozing), 0);
    chk("rst_buzzer",   int'(buzzer), 0);
    chk("rst_set_err",  int'(set_err), 0);
    chk("rst_alm_hour", int'(alm_hour), 0);
    chk("rst_alm_min",  int'(alm_minute), 0);
    tick(); tick();
    rst = 1'b0;

    //        en set sh  sm stp snz  h   m   s  ring snz err ah  am
    tbl.push_back(mk(1, 1,  7, 30, 0, 0,  7, 29, 58, 0, 0, 0,  7, 30));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0,  7, 29, 59, 0, 0, 0,  7, 30));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0,  7, 30,  0, 1, 0, 0,  7, 30));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0,  7, 30,  0, 1, 0, 0,  7, 30));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0,  7, 30,  1, 1, 0, 0,  7, 30));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0,  7, 30,  2, 1, 0, 0,  7, 30));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0,  7, 30,  3, 0, 0, 0,  7, 30));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0,  7, 30,  4, 0, 0, 0,  7, 30));
    tbl.push_back(mk(1, 1, 24,  0, 0, 0,  7, 30,  5, 0, 0, 1,  7, 30));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0,  7, 30,  6, 0, 0, 0,  7, 30));
    tbl.push_back(mk(1, 1,  5, 60, 0, 0,  7, 30,  7, 0, 0, 1,  7, 30));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0,  7, 30,  8, 0, 0, 0,  7, 30));
    tbl.push_back(mk(1, 1, 23, 58, 0, 0, 23, 57, 59, 0, 0, 0, 23, 58));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 23, 58,  0, 1, 0, 0, 23, 58));
    tbl.push_back(mk(1, 0,  0,  0, 0, 1, 23, 58,  0, 0, 1, 0, 23, 58));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0,  0,  2, 59, 0, 1, 0, 23, 58));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0,  0,  3,  0, 1, 0, 0, 23, 58));
    tbl.push_back(mk(1, 0,  0,  0, 1, 0,  0,  3,  0, 0, 0, 0, 23, 58));
    tbl.push_back(mk(1, 0,  0,  0, 1, 1,  0,  3,  1, 0, 0, 0, 23, 58));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 23, 58, 30, 0, 0, 0, 23, 58));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 23, 58,  0, 1, 0, 0, 23, 58));
    tbl.push_back(mk(1, 0,  0,  0, 1, 1, 23, 58,  0, 0, 0, 0, 23, 58));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 23, 58, 59, 0, 0, 0, 23, 58));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 23, 58,  0, 1, 0, 0, 23, 58));
    tbl.push_back(mk(0, 0,  0,  0, 1, 0, 23, 58,  0, 0, 0, 0, 23, 58));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 23, 58,  1, 0, 0, 0, 23, 58));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 23, 58,  0, 1, 0, 0, 23, 58));
    tbl.push_back(mk(1, 1,  6, 15, 0, 0, 23, 58,  0, 0, 0, 0,  6, 15));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0,  6, 14, 59, 0, 0, 0,  6, 15));

    foreach (tbl[i]) begin
      alarm_en = tbl[i].en; set_alarm = tbl[i].set;
      set_hour = tbl[i].sh; set_minute = tbl[i].sm;
      stop = tbl[i].stp; snooze = tbl[i].snz;
      hour = tbl[i].h; minute = tbl[i].m; second = tbl[i].s;
      sb.push_back('{ring: tbl[i].e_ring, snz: tbl[i].e_snz, err: tbl[i].e_err,
                     ah: tbl[i].e_ah, am: tbl[i].e_am});
      tick();
      e = sb.pop_front();
      chk($sformatf("v%0d_ringing", i),  int'(ringing),    int'(e.ring));
      chk($sformatf("v%0d_snoozing", i), int'(snoozing),   int'(e.snz));
      chk($sformatf("v%0d_set_err", i),  int'(set_err),    int'(e.err));
      chk($sformatf("v%0d_alm_hour", i), int'(alm_hour),   int'(e.ah));
      chk($sformatf("v%0d_alm_min", i),  int'(alm_minute), int'(e.am));
    end
    set_alarm = 1'b0; stop = 1'b0; snooze = 1'b0;

    // Buzzer: after entry edge k, buzzer = (k / TD) % 2; time held so no strobes occur.
    set_time(6, 15, 0);
    for (int k = 0; k < 3 * int'(TD); k++) begin
      tick();
      chk($sformatf("buz_k%0d", k), int'(buzzer), (k / int'(TD)) % 2);
      chk($sformatf("buz_ring_k%0d", k), int'(ringing), 1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_buzzer", int'(buzzer), 0);
    chk("stop_ringing", int'(ringing), 0);

    // Re-ring, let buzzer go high, then pulse rst between clock edges.
    set_time(6, 15, 1);
    tick();
    set_time(6, 15, 0);
    tick();
    chk("rering", int'(ringing), 1);
    for (int k = 1; k <= int'(TD) + 1; k++) tick();
    chk("pre_rst_buzzer", int'(buzzer), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_buzzer",   int'(buzzer), 0);
    chk("arst_ringing",  int'(ringing), 0);
    chk("arst_alm_hour", int'(alm_hour), 0);
    chk("arst_alm_min",  int'(alm_minute), 0);
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_ringing", int'(ringing), 0);
    chk("post_rst_buzzer",  int'(buzzer), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
